// File: rtl/prga_decrypt_if.sv
// Memory-side bus of the RC4 PRGA stage: start handshake plus S, CT and PT memory ports.
// Handshake: a run starts on a rising edge where en=1 and rdy=1; en is ignored while rdy=0.
interface prga_decrypt_if;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    modport master (
        input  en, s_rddata, ct_rddata,
        output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

    modport slave (
        output en, s_rddata, ct_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );
endinterface

// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation: decrypts a length-prefixed CT memory into PT memory,
// swapping the S permutation in place. Bus outputs are registered on entry to each state.
module prga_decrypt #(
    parameter logic [7:0] LEN_ADDR = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prga_decrypt_if.master        bus,
    output logic [3:0]            dbg_state,
    output logic [7:0]            dbg_count_i,
    output logic [7:0]            dbg_count_j,
    output logic [39:0]           dbg_data
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RDLEN1 = 4'd1,
        RDLEN2 = 4'd2,
        WRLEN  = 4'd3,
        INCI   = 4'd4,
        RDSI1  = 4'd5,
        RDSI2  = 4'd6,
        CALCJ  = 4'd7,
        RDSJ1  = 4'd8,
        RDSJ2  = 4'd9,
        WRSI   = 4'd10,
        WRSJ   = 4'd11,
        RDPK1  = 4'd12,
        RDPK2  = 4'd13,
        WRPT   = 4'd14
    } state_t;

    state_t     state;
    logic [7:0] count_i;
    logic [7:0] count_j;
    logic [7:0] len;
    logic [7:0] si;
    logic [7:0] sj;
    logic [7:0] pad;
    logic [7:0] ctb;

    assign dbg_state   = state;
    assign dbg_count_i = count_i;
    assign dbg_count_j = count_j;
    assign dbg_data    = {len, si, sj, pad, ctb};

    // Each transition loads the bus outputs the destination state must present,
    // so values that land on the same edge are taken straight from their source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.rdy       <= 1'b1;
            bus.s_addr    <= 8'd0;
            bus.s_wrdata  <= 8'd0;
            bus.s_wren    <= 1'b0;
            bus.ct_addr   <= 8'd0;
            bus.pt_addr   <= 8'd0;
            bus.pt_wrdata <= 8'd0;
            bus.pt_wren   <= 1'b0;
            count_i       <= 8'd0;
            count_j       <= 8'd0;
            len           <= 8'd0;
            si            <= 8'd0;
            sj            <= 8'd0;
            pad           <= 8'd0;
            ctb           <= 8'd0;
        end else begin
            bus.s_addr    <= 8'd0;
            bus.s_wrdata  <= 8'd0;
            bus.s_wren    <= 1'b0;
            bus.ct_addr   <= 8'd0;
            bus.pt_addr   <= 8'd0;
            bus.pt_wrdata <= 8'd0;
            bus.pt_wren   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state       <= RDLEN1;
                        bus.rdy     <= 1'b0;
                        bus.ct_addr <= LEN_ADDR;
                    end
                end
                RDLEN1: begin
                    count_i     <= 8'd0;
                    count_j     <= 8'd0;
                    bus.ct_addr <= LEN_ADDR;
                    state       <= RDLEN2;
                end
                RDLEN2: begin
                    len           <= bus.ct_rddata;
                    bus.pt_addr   <= LEN_ADDR;
                    bus.pt_wrdata <= bus.ct_rddata;
                    bus.pt_wren   <= 1'b1;
                    state         <= WRLEN;
                end
                WRLEN: begin
                    if (len == 8'd0) begin
                        state   <= IDLE;
                        bus.rdy <= 1'b1;
                    end else begin
                        state <= INCI;
                    end
                end
                INCI: begin
                    count_i    <= count_i + 8'd1;
                    bus.s_addr <= count_i + 8'd1;
                    state      <= RDSI1;
                end
                RDSI1: begin
                    bus.s_addr <= count_i;
                    state      <= RDSI2;
                end
                RDSI2: begin
                    si    <= bus.s_rddata;
                    state <= CALCJ;
                end
                CALCJ: begin
                    count_j    <= count_j + si;
                    bus.s_addr <= count_j + si;
                    state      <= RDSJ1;
                end
                RDSJ1: begin
                    bus.s_addr <= count_j;
                    state      <= RDSJ2;
                end
                RDSJ2: begin
                    sj           <= bus.s_rddata;
                    bus.s_addr   <= count_i;
                    bus.s_wrdata <= bus.s_rddata;
                    bus.s_wren   <= 1'b1;
                    state        <= WRSI;
                end
                WRSI: begin
                    bus.s_addr   <= count_j;
                    bus.s_wrdata <= si;
                    bus.s_wren   <= 1'b1;
                    state        <= WRSJ;
                end
                WRSJ: begin
                    bus.s_addr  <= si + sj;
                    bus.ct_addr <= count_i;
                    state       <= RDPK1;
                end
                RDPK1: begin
                    bus.s_addr  <= si + sj;
                    bus.ct_addr <= count_i;
                    state       <= RDPK2;
                end
                RDPK2: begin
                    pad           <= bus.s_rddata;
                    ctb           <= bus.ct_rddata;
                    bus.pt_addr   <= count_i;
                    bus.pt_wrdata <= bus.s_rddata ^ bus.ct_rddata;
                    bus.pt_wren   <= 1'b1;
                    state         <= WRPT;
                end
                WRPT: begin
                    // count_i never wraps: the last byte index equals len.
                    if (count_i == len) begin
                        state   <= IDLE;
                        bus.rdy <= 1'b1;
                    end else begin
                        state <= INCI;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus.rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: synchronous S/CT/PT memories, a software RC4 model and
// a negedge compare process checking every PT write against the model.
module tb_prga_decrypt;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prga_decrypt_if bus();
  logic [3:0]  dbg_state;
  logic [7:0]  dbg_count_i;
  logic [7:0]  dbg_count_j;
  logic [39:0] dbg_data;

  prga_decrypt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state   (dbg_state),
    .dbg_count_i (dbg_count_i),
    .dbg_count_j (dbg_count_j),
    .dbg_data    (dbg_data)
  );

  // ---------------- memories ----------------
  logic [7:0] s_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic       ld_en;
  logic [1:0] ld_sel;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
    if (bus.s_wren)  s_mem[bus.s_addr]   <= bus.s_wrdata;
    if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    if (ld_en) begin
      case (ld_sel)
        2'd0:    s_mem[ld_addr]  <= ld_data;
        2'd1:    ct_mem[ld_addr] <= ld_data;
        default: pt_mem[ld_addr] <= ld_data;
      endcase
    end
  end

  // ---------------- model state / scoreboard ----------------
  logic [7:0]  m_s [256];
  logic [7:0]  ct_img [256];
  logic [7:0]  exp_pt [256];
  logic [15:0] exp_q [$];
  logic [15:0] wr_log [$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.s_wren) wr_log.push_back({bus.s_addr, bus.s_wrdata});
      if (bus.pt_wren) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pt_extra_write: addr=%0h data=%0h, no write expected", bus.pt_addr, bus.pt_wrdata);
        end else begin
          chk("pt_write", 32'({bus.pt_addr, bus.pt_wrdata}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input logic [1:0] sel, input logic [7:0] addr, input logic [7:0] data);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = addr;
    ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_s_from_model();
    for (int n = 0; n < 256; n++) load(2'd0, 8'(n), m_s[n]);
  endtask

  task automatic load_ct(input int len);
    ct_img[0] = 8'(len);
    for (int n = 1; n <= len; n++) ct_img[n] = 8'($urandom_range(0, 255));
    for (int n = 0; n <= len; n++) load(2'd1, 8'(n), ct_img[n]);
  endtask

  task automatic ksa_model(input logic [23:0] key);
    logic [7:0] j, t, kb;
    for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      kb = (n % 3 == 0) ? key[23:16] : (n % 3 == 1) ? key[15:8] : key[7:0];
      j = j + m_s[n] + kb;
      t = m_s[n]; m_s[n] = m_s[j]; m_s[j] = t;
    end
  endtask

  // Plain software RC4 PRGA over the model S; queues the PT writes in order.
  task automatic rc4_model(input int len);
    logic [7:0] i, j, t, k, b;
    exp_pt[0] = 8'(len);
    exp_q.push_back({8'd0, 8'(len)});
    i = 8'd0;
    j = 8'd0;
    for (int n = 1; n <= len; n++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      k = m_s[i] + m_s[j];
      b = m_s[k] ^ ct_img[n];
      exp_pt[n] = b;
      exp_q.push_back({i, b});
    end
  endtask

  task automatic run(input bit inject, output int cycles);
    wr_log.delete();
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    cycles = 0;
    while (bus.rdy == 1'b0 && cycles < 4000) begin
      cycles++;
      bus.en = (inject && dbg_state == 4'd10);
      @(negedge clk);
    end
    bus.en = 1'b0;
  endtask

  task automatic check_s(input string name);
    int d = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) d++;
    chk(name, 32'(d), 32'd0);
  endtask

  task automatic check_pt(input string name, input int len);
    int d = 0;
    for (int n = 0; n <= len; n++) if (pt_mem[n] !== exp_pt[n]) d++;
    chk(name, 32'(d), 32'd0);
  endtask

  // ---------------- tests ----------------
  initial begin
    int c;
    int w;
    logic [23:0] key;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    ld_en  = 1'b0;
    ld_sel = 2'd0;
    ld_addr = 8'd0;
    ld_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("t0_rdy", 32'(bus.rdy), 32'd1);
    chk("t0_state", 32'(dbg_state), 32'd0);
    chk("t0_wrens", 32'({bus.s_wren, bus.pt_wren}), 32'd0);
    chk("t0_addrs", 32'({bus.s_addr, bus.ct_addr, bus.pt_addr}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: asynchronous reset in the middle of a run
    key = 24'($urandom_range(0, 32'hFFFFFF));
    ksa_model(key);
    load_s_from_model();
    load_ct(5);
    rc4_model(5);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    w = 0;
    while (dbg_state != 4'd8 && w < 100) begin w++; @(negedge clk); end
    chk("t1_reach_rdsj1", 32'(dbg_state), 32'd8);
    rst_n = 1'b0;
    #1;
    chk("t1_state", 32'(dbg_state), 32'd0);
    chk("t1_rdy", 32'(bus.rdy), 32'd1);
    chk("t1_wrens", 32'({bus.s_wren, bus.pt_wren}), 32'd0);
    chk("t1_counts", 32'({dbg_count_i, dbg_count_j}), 32'd0);
    chk("t1_regs", dbg_data[31:0], 32'd0);
    chk("t1_len", 32'(dbg_data[39:32]), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T2: handshake and known-answer with key 00033C, one zero byte
    ksa_model(24'h00033C);
    load_s_from_model();
    ct_img[0] = 8'd1;
    ct_img[1] = 8'd0;
    load(2'd1, 8'd0, 8'd1);
    load(2'd1, 8'd1, 8'd0);
    rc4_model(1);
    run(1'b0, c);
    chk("t2_busy", 32'(c), 32'd14);
    chk("t2_pt0", 32'(pt_mem[0]), 32'h01);
    chk("t2_pt1", 32'(pt_mem[1]), 32'h1d);
    chk("t2_s1", 32'(s_mem[1]), 32'h49);
    chk("t2_s4", 32'(s_mem[4]), 32'h04);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);
    check_s("t2_s_final");

    // T3: len=0 with en held high -> immediate restart, S untouched
    load(2'd1, 8'd0, 8'd0);
    ct_img[0] = 8'd0;
    load(2'd2, 8'd0, 8'hAA);
    rc4_model(0);
    rc4_model(0);
    wr_log.delete();
    bus.en = 1'b1;
    @(negedge clk);
    c = 0;
    while (bus.rdy == 1'b0 && c < 100) begin c++; @(negedge clk); end
    chk("t3_busy", 32'(c), 32'd3);
    @(negedge clk);
    chk("t3_restart", 32'(bus.rdy), 32'd0);
    bus.en = 1'b0;
    c = 1;
    @(negedge clk);
    while (bus.rdy == 1'b0 && c < 100) begin c++; @(negedge clk); end
    chk("t3_busy2", 32'(c), 32'd3);
    chk("t3_no_s_write", 32'(wr_log.size()), 32'd0);
    chk("t3_pt0", 32'(pt_mem[0]), 32'd0);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // T4: golden 255-byte message with key 00033C
    ksa_model(24'h00033C);
    load_s_from_model();
    load_ct(255);
    rc4_model(255);
    run(1'b0, c);
    chk("t4_busy", 32'(c), 32'd2808);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    check_pt("t4_pt_final", 255);
    check_s("t4_s_final");

    // T5: en pulsed during every WRSI of a random-key run is ignored
    key = 24'($urandom_range(0, 32'hFFFFFF));
    ksa_model(key);
    load_s_from_model();
    load_ct(3);
    rc4_model(3);
    run(1'b1, c);
    chk("t5_busy", 32'(c), 32'd36);
    for (int n = 0; n < 3; n++) begin
      chk("t5_stays_idle", 32'({bus.rdy, dbg_state}), 32'h10);
      @(negedge clk);
    end
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    check_s("t5_s_final");

    // T6: S[1]=FF, S[2]=3 makes j land on i=2 for the second byte
    for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
    m_s[1] = 8'hFF; m_s[8'hFF] = 8'h01;
    m_s[2] = 8'h03; m_s[3] = 8'h02;
    load_s_from_model();
    load_ct(2);
    rc4_model(2);
    run(1'b0, c);
    chk("t6_busy", 32'(c), 32'd25);
    chk("t6_log_size", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() >= 4) begin
      chk("t6_wrsi", 32'(wr_log[2]), 32'h0203);
      chk("t6_wrsj", 32'(wr_log[3]), 32'h0203);
    end
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    check_pt("t6_pt_final", 2);
    check_s("t6_s_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
